// File: rtl/fpu_seq_pkg.sv
// Shared types, op codes and latency lookup for the FPU issue sequencer.
package fpu_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } seq_state_e;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MCMP    = 3'd2;
    localparam logic [2:0] OP_CMP     = 3'd3;
    localparam logic [2:0] OP_MUL     = 3'd4;
    localparam logic [2:0] OP_RECIP   = 3'd5;
    localparam logic [2:0] OP_DIV     = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Maps an op code to its FPU pipeline depth; the illegal code has no latency.
    function automatic logic [7:0] lat_sel(
        input logic [2:0] mode,
        input logic [7:0] lat_add,
        input logic [7:0] lat_cmp,
        input logic [7:0] lat_mul,
        input logic [7:0] lat_recip,
        input logic [7:0] lat_div
    );
        logic [7:0] lat;
        case (mode)
            OP_ADD, OP_SUB:  lat = lat_add;
            OP_MCMP, OP_CMP: lat = lat_cmp;
            OP_MUL:          lat = lat_mul;
            OP_RECIP:        lat = lat_recip;
            OP_DIV:          lat = lat_div;
            default:         lat = 8'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/fpu_result_class.sv
// Combinational IEEE-style classifier producing {nan, inf, zero, denorm}.
module fpu_result_class #(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic [WIDTH-1:0] value,
    output logic [3:0]       flags
);
    logic [EXP_WIDTH-1:0] exp_field;
    logic [MAN_WIDTH-1:0] man_field;
    logic                 unused_sign;
    logic                 exp_ones;
    logic                 exp_zero;
    logic                 man_zero;

    assign exp_field   = value[EXP_WIDTH+MAN_WIDTH-1:MAN_WIDTH];
    assign man_field   = value[MAN_WIDTH-1:0];
    assign unused_sign = value[WIDTH-1];

    assign exp_ones = &exp_field;
    assign exp_zero = ~|exp_field;
    assign man_zero = ~|man_field;

    assign flags = {exp_ones & ~man_zero,
                    exp_ones &  man_zero,
                    exp_zero &  man_zero,
                    exp_zero & ~man_zero};
endmodule

// File: rtl/fpu_issue_seq.sv
// Single-outstanding operation sequencer in front of the FPU.
// Optional flag classification is enabled with the FPU_SEQ_FLAGS_EN macro.
module fpu_issue_seq
    import fpu_seq_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23,
    parameter int LAT_ADD   = 4,
    parameter int LAT_CMP   = 2,
    parameter int LAT_MUL   = 4,
    parameter int LAT_RECIP = 8,
    parameter int LAT_DIV   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_mode,
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic [2:0]       fpu_mode,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_mode,
    output logic             out_err,
    output logic [3:0]       out_flags,
    output logic             busy
);
    localparam logic [7:0] L_ADD   = 8'(LAT_ADD);
    localparam logic [7:0] L_CMP   = 8'(LAT_CMP);
    localparam logic [7:0] L_MUL   = 8'(LAT_MUL);
    localparam logic [7:0] L_RECIP = 8'(LAT_RECIP);
    localparam logic [7:0] L_DIV   = 8'(LAT_DIV);

    seq_state_e       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [2:0]       fm_q, fm_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [2:0]       omode_q, omode_d;
    logic             err_q, err_d;
    logic             cap_en;
    logic             illegal_take;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fa_d         = fa_q;
        fb_d         = fb_q;
        fm_d         = fm_q;
        res_d        = res_q;
        omode_d      = omode_q;
        err_d        = err_q;
        cap_en       = 1'b0;
        illegal_take = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_mode == OP_ILLEGAL) begin
                        illegal_take = 1'b1;
                        res_d        = '0;
                        omode_d      = OP_ILLEGAL;
                        err_d        = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        fa_d    = in_a;
                        fb_d    = in_b;
                        fm_d    = in_mode;
                        cnt_d   = lat_sel(in_mode, L_ADD, L_CMP, L_MUL, L_RECIP, L_DIV);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A count of 1 always leaves WAIT, so the counter cannot wrap.
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    cap_en  = 1'b1;
                    res_d   = fpu_result;
                    omode_d = fm_q;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            fa_q    <= '0;
            fb_q    <= '0;
            fm_q    <= 3'd0;
            res_q   <= '0;
            omode_q <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fm_q    <= fm_d;
            res_q   <= res_d;
            omode_q <= omode_d;
            err_q   <= err_d;
        end
    end

`ifdef FPU_SEQ_FLAGS_EN
    logic [3:0] cls_flags;
    logic [3:0] flags_q, flags_d;

    fpu_result_class #(
        .WIDTH     (WIDTH),
        .EXP_WIDTH (EXP_WIDTH),
        .MAN_WIDTH (MAN_WIDTH)
    ) u_class (
        .value (fpu_result),
        .flags (cls_flags)
    );

    // Compare modes return a fixed-point result, so IEEE classes are meaningless there.
    always_comb begin
        flags_d = flags_q;
        if (illegal_take) begin
            flags_d = 4'b0;
        end else if (cap_en) begin
            flags_d = (fm_q == OP_MCMP || fm_q == OP_CMP) ? 4'b0 : cls_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'b0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign out_flags = flags_q;
`else
    assign out_flags = 4'b0;
`endif

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign fpu_a      = fa_q;
    assign fpu_b      = fb_q;
    assign fpu_mode   = fm_q;
    assign out_result = res_q;
    assign out_mode   = omode_q;
    assign out_err    = err_q;
endmodule
